// File: rtl/seg7_pkg.sv
// Shared types and helpers for the 7-segment scan controller.
package seg7_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    typedef enum logic {
        ST_GUARD = 1'b0,
        ST_ON    = 1'b1
    } state_e;

    // $clog2 clamped so that single-value ranges still get a 1-bit register.
    function automatic int unsigned clog2_min1(input int unsigned v);
        int unsigned w;
        w = $clog2(v);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/Seg7.sv
// Hex nibble to 7-segment decoder, segments {g,f,e,d,c,b,a}, active-high.
module Seg7
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib_i,
    output logic [SEG_W-1:0] seg_c_o
);

    // Plain lookup of the hex glyph for each nibble value.
    always_comb begin
        seg_c_o = '0;
        case (nib_i)
            4'h0: seg_c_o = 7'h3F;
            4'h1: seg_c_o = 7'h06;
            4'h2: seg_c_o = 7'h5B;
            4'h3: seg_c_o = 7'h4F;
            4'h4: seg_c_o = 7'h66;
            4'h5: seg_c_o = 7'h6D;
            4'h6: seg_c_o = 7'h7D;
            4'h7: seg_c_o = 7'h07;
            4'h8: seg_c_o = 7'h7F;
            4'h9: seg_c_o = 7'h6F;
            4'hA: seg_c_o = 7'h77;
            4'hB: seg_c_o = 7'h7C;
            4'hC: seg_c_o = 7'h39;
            4'hD: seg_c_o = 7'h5E;
            4'hE: seg_c_o = 7'h79;
            4'hF: seg_c_o = 7'h71;
            default: seg_c_o = '0;
        endcase
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexed scan controller driving a bank of 7-segment digits
// through one shared decoder, with double-buffered display data.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned ON_CYCLES    = 1000,
    parameter int unsigned GUARD_CYCLES = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_load,
    input  logic [NIB_W*DIGITS-1:0]   iv_data,
    input  logic [DIGITS-1:0]         iv_blank,
    input  logic [DIGITS-1:0]         iv_dp,
    output logic [DIGITS-1:0]         ov_an,
    output logic [SEG_W-1:0]          ov_seg,
    output logic                      o_dp,
    output logic                      o_frame
);

    localparam int unsigned DW         = NIB_W * DIGITS;
    localparam int unsigned IW         = clog2_min1(DIGITS);
    localparam int unsigned MAXC       = (ON_CYCLES > GUARD_CYCLES) ? ON_CYCLES : GUARD_CYCLES;
    localparam int unsigned CW         = clog2_min1(MAXC);
    localparam int unsigned ON_LAST    = ON_CYCLES - 1;
    // With no guard the post-reset GUARD state still lasts a single cycle.
    localparam int unsigned GUARD_LAST = (GUARD_CYCLES == 0) ? 0 : GUARD_CYCLES - 1;

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DW-1:0]     act_data_q, act_data_d;
    logic [DIGITS-1:0] act_blank_q, act_blank_d;
    logic [DIGITS-1:0] act_dp_q, act_dp_d;
    logic [DW-1:0]     pend_data_q, pend_data_d;
    logic [DIGITS-1:0] pend_blank_q, pend_blank_d;
    logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic              pend_valid_q, pend_valid_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [SEG_W-1:0]  seg_q, seg_d;
    logic              dp_q, dp_d;
    logic              frame_q, frame_d;

    logic [IW-1:0]     idx_next;
    logic              enter_on;
    logic [NIB_W-1:0]  cur_nib;
    logic              cur_blank;
    logic              cur_dp;
    logic [SEG_W-1:0]  cur_seg;

    // Select the active nibble, blank and dp bits for the current digit.
    always_comb begin
        cur_nib   = '0;
        cur_blank = 1'b0;
        cur_dp    = 1'b0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                cur_nib   = act_data_q[NIB_W*k +: NIB_W];
                cur_blank = act_blank_q[k];
                cur_dp    = act_dp_q[k];
            end
        end
    end

    Seg7 u_seg7 (
        .nib_i   (cur_nib),
        .seg_c_o (cur_seg)
    );

    // Next-state: scan FSM, slot counter, digit index and buffer promotion.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        idx_d        = idx_q;
        act_data_d   = act_data_q;
        act_blank_d  = act_blank_q;
        act_dp_d     = act_dp_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        pend_dp_d    = pend_dp_q;
        pend_valid_d = pend_valid_q;
        frame_d      = 1'b0;
        enter_on     = 1'b0;
        idx_next     = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);

        case (state_q)
            ST_GUARD: begin
                if (cnt_q == CW'(GUARD_LAST)) begin
                    enter_on = 1'b1;
                end
            end
            ST_ON: begin
                if (cnt_q == CW'(ON_LAST)) begin
                    if (GUARD_CYCLES == 0) begin
                        enter_on = 1'b1;
                    end else begin
                        state_d = ST_GUARD;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_GUARD;
                cnt_d   = '0;
            end
        endcase

        if (enter_on) begin
            state_d = ST_ON;
            cnt_d   = '0;
            idx_d   = idx_next;
            frame_d = (idx_next == '0);
        end

        // Promotion uses the pending set as it stood before this edge's load.
        if (frame_d && pend_valid_q) begin
            act_data_d   = pend_data_q;
            act_blank_d  = pend_blank_q;
            act_dp_d     = pend_dp_q;
            pend_valid_d = 1'b0;
        end

        if (i_load) begin
            pend_data_d  = iv_data;
            pend_blank_d = iv_blank;
            pend_dp_d    = iv_dp;
            pend_valid_d = 1'b1;
        end
    end

    // Pin values for the digit currently held in state/index.
    always_comb begin
        an_d  = '0;
        seg_d = '0;
        dp_d  = 1'b0;
        if (state_q == ST_ON) begin
            an_d  = DIGITS'(1) << idx_q;
            seg_d = cur_blank ? '0 : cur_seg;
            dp_d  = cur_dp;
        end
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_GUARD;
            cnt_q        <= '0;
            idx_q        <= IW'(DIGITS - 1);
            act_data_q   <= '0;
            act_blank_q  <= '0;
            act_dp_q     <= '0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            pend_dp_q    <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= '0;
            seg_q        <= '0;
            dp_q         <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            act_data_q   <= act_data_d;
            act_blank_q  <= act_blank_d;
            act_dp_q     <= act_dp_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            pend_dp_q    <= pend_dp_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_q      <= frame_d;
        end
    end

    assign ov_an   = an_q;
    assign ov_seg  = seg_q;
    assign o_dp    = dp_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan: a 4-digit instance with directed and random loads,
// and a 1-digit no-guard instance, both checked every cycle against a
// slot-arithmetic model of the scan schedule.
module tb_seg7_scan;

    localparam int D   = 4;
    localparam int ONC = 4;
    localparam int GC  = 1;
    localparam int D2  = 1;
    localparam int ON2 = 4;
    localparam int G2  = 0;

    logic        clk;
    logic        rst_n, rst2_n;
    logic        ld;
    logic [15:0] dat;
    logic [3:0]  blank, dpi;
    logic [3:0]  ov_an;
    logic [6:0]  ov_seg;
    logic        o_dp, o_frame;

    logic        ld2;
    logic [3:0]  dat2;
    logic [0:0]  blank2, dpi2;
    logic [0:0]  an2;
    logic [6:0]  seg2;
    logic        dp2, frame2;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg7_scan #(.DIGITS(D), .ON_CYCLES(ONC), .GUARD_CYCLES(GC)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_load(ld), .iv_data(dat),
        .iv_blank(blank), .iv_dp(dpi), .ov_an(ov_an), .ov_seg(ov_seg),
        .o_dp(o_dp), .o_frame(o_frame)
    );

    seg7_scan #(.DIGITS(D2), .ON_CYCLES(ON2), .GUARD_CYCLES(G2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_load(ld2), .iv_data(dat2),
        .iv_blank(blank2), .iv_dp(dpi2), .ov_an(an2), .ov_seg(seg2),
        .o_dp(dp2), .o_frame(frame2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference decoder built from per-segment on-sets over the 16 glyphs.
    function automatic logic [6:0] seg7_alt(input logic [3:0] v);
        logic [15:0] m [7];
        logic [6:0]  r;
        m[0] = 16'hD7ED; m[1] = 16'h279F; m[2] = 16'h2FFB; m[3] = 16'h7B6D;
        m[4] = 16'hFD45; m[5] = 16'hDF71; m[6] = 16'hEF7C;
        for (int s = 0; s < 7; s++) r[s] = m[s][v];
        return r;
    endfunction

    // Schedule after m edges: first guard, then repeating ON+GUARD slots.
    function automatic bit f_on(input int m, input int d, input int onc, input int g);
        int g0 = (g == 0) ? 1 : g;
        if (m < g0) return 1'b0;
        return ((m - g0) % (onc + g)) < onc;
    endfunction

    function automatic int f_dig(input int m, input int d, input int onc, input int g);
        int g0 = (g == 0) ? 1 : g;
        if (m < g0) return 0;
        return ((m - g0) / (onc + g)) % d;
    endfunction

    function automatic bit f_start(input int n, input int d, input int onc, input int g);
        int g0 = (g == 0) ? 1 : g;
        int q;
        if (n < g0) return 1'b0;
        q = n - g0;
        return ((q % (onc + g)) == 0) && (((q / (onc + g)) % d) == 0);
    endfunction

    // Model of the 4-digit instance: pins lag the schedule by one edge.
    int          e;
    logic [15:0] m_data, m_pdata;
    logic [3:0]  m_blank, m_dp, m_pblank, m_pdp;
    logic        m_pv;
    logic [3:0]  x_an;
    logic [6:0]  x_seg;
    logic        x_dp, x_frame;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e <= 0;
            m_data <= '0; m_blank <= '0; m_dp <= '0;
            m_pdata <= '0; m_pblank <= '0; m_pdp <= '0; m_pv <= 1'b0;
            x_an <= '0; x_seg <= '0; x_dp <= 1'b0; x_frame <= 1'b0;
        end else begin
            x_an    <= f_on(e, D, ONC, GC) ? (4'b0001 << f_dig(e, D, ONC, GC)) : 4'b0000;
            x_seg   <= (f_on(e, D, ONC, GC) && !m_blank[f_dig(e, D, ONC, GC)])
                       ? seg7_alt(m_data[4*f_dig(e, D, ONC, GC) +: 4]) : 7'h00;
            x_dp    <= f_on(e, D, ONC, GC) && m_dp[f_dig(e, D, ONC, GC)];
            x_frame <= f_start(e + 1, D, ONC, GC);
            if (f_start(e + 1, D, ONC, GC) && m_pv) begin
                m_data <= m_pdata; m_blank <= m_pblank; m_dp <= m_pdp;
            end
            if (ld) begin
                m_pdata <= dat; m_pblank <= blank; m_pdp <= dpi; m_pv <= 1'b1;
            end else if (f_start(e + 1, D, ONC, GC)) begin
                m_pv <= 1'b0;
            end
            e <= e + 1;
        end
    end

    // Model of the 1-digit no-guard instance, which never loads.
    int          e2;
    logic        x2_an, x2_frame;
    logic [6:0]  x2_seg;

    always @(posedge clk or negedge rst2_n) begin
        if (!rst2_n) begin
            e2 <= 0; x2_an <= 1'b0; x2_seg <= '0; x2_frame <= 1'b0;
        end else begin
            x2_an    <= f_on(e2, D2, ON2, G2);
            x2_seg   <= f_on(e2, D2, ON2, G2) ? seg7_alt(4'h0) : 7'h00;
            x2_frame <= f_start(e2 + 1, D2, ON2, G2);
            e2 <= e2 + 1;
        end
    end

    // Every-cycle comparison against both models.
    always @(negedge clk) begin
        check("an", {28'b0, ov_an}, {28'b0, x_an});
        check("seg", {25'b0, ov_seg}, {25'b0, x_seg});
        check("dp", {31'b0, o_dp}, {31'b0, x_dp});
        check("frame", {31'b0, o_frame}, {31'b0, x_frame});
        check("an_onehot", {31'b0, $onehot0(ov_an)}, 32'd1);
        check("an2", {31'b0, an2}, {31'b0, x2_an});
        check("seg2", {25'b0, seg2}, {25'b0, x2_seg});
        check("dp2", {31'b0, dp2}, 32'd0);
        check("frame2", {31'b0, frame2}, {31'b0, x2_frame});
    end

    task automatic wait_frame(output int c);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (o_frame !== 1'b1 && c < 100);
        check("frame_seen", {31'b0, o_frame}, 32'd1);
    endtask

    int c;

    initial begin
        rst_n = 1'b0; rst2_n = 1'b0;
        ld = 1'b0; dat = '0; blank = '0; dpi = '0;
        ld2 = 1'b0; dat2 = '0; blank2 = '0; dpi2 = '0;
        repeat (3) @(negedge clk);
        check("rst_an", {28'b0, ov_an}, 32'd0);
        check("rst_seg", {25'b0, ov_seg}, 32'd0);
        rst_n = 1'b1; rst2_n = 1'b1;

        // Reset then idle: first slot is digit 0 and is a frame boundary.
        @(negedge clk);
        check("first_frame", {31'b0, o_frame}, 32'd1);
        check("first_an_off", {28'b0, ov_an}, 32'd0);
        check("first_frame2", {31'b0, frame2}, 32'd1);
        @(negedge clk);
        check("first_an", {28'b0, ov_an}, 32'h1);
        check("first_seg", {25'b0, ov_seg}, 32'h3F);
        wait_frame(c);
        wait_frame(c);
        check("frame_period", c, 32'd20);

        // Mid-frame load becomes visible only after the next boundary.
        repeat (7) @(negedge clk);
        ld = 1'b1; dat = 16'h4321;
        @(negedge clk);
        ld = 1'b0;
        wait_frame(c);
        @(negedge clk);
        check("ld4321_d0", {25'b0, ov_seg}, 32'h06);
        repeat (15) @(negedge clk);
        check("ld4321_an3", {28'b0, ov_an}, 32'h8);
        check("ld4321_d3", {25'b0, ov_seg}, 32'h66);

        // Two loads before one boundary: last one wins.
        ld = 1'b1; dat = 16'hAAAA;
        @(negedge clk);
        dat = 16'hBEEF;
        @(negedge clk);
        ld = 1'b0;
        wait_frame(c);
        @(negedge clk);
        check("beef_d0", {25'b0, ov_seg}, 32'h71);
        repeat (15) @(negedge clk);
        check("beef_d3", {25'b0, ov_seg}, 32'h7C);

        // Load during the frame pulse waits a whole extra frame.
        wait_frame(c);
        ld = 1'b1; dat = 16'h1234;
        @(negedge clk);
        ld = 1'b0;
        check("late_hold_d0", {25'b0, ov_seg}, 32'h71);
        wait_frame(c);
        @(negedge clk);
        check("late_new_d0", {25'b0, ov_seg}, 32'h66);

        // Blank and decimal point per digit.
        ld = 1'b1; dat = 16'h8888; blank = 4'b0101; dpi = 4'b1000;
        @(negedge clk);
        ld = 1'b0;
        wait_frame(c);
        @(negedge clk);
        check("blank_d0_seg", {25'b0, ov_seg}, 32'h0);
        check("blank_d0_dp", {31'b0, o_dp}, 32'd0);
        repeat (15) @(negedge clk);
        check("dp_d3_an", {28'b0, ov_an}, 32'h8);
        check("dp_d3_dp", {31'b0, o_dp}, 32'd1);
        check("dp_d3_seg", {25'b0, ov_seg}, 32'h7F);

        // Random loads against the model.
        repeat (3000) begin
            @(negedge clk);
            ld    = ($urandom_range(0, 7) == 0);
            dat   = 16'($urandom);
            blank = 4'($urandom);
            dpi   = 4'($urandom);
        end
        @(negedge clk);
        ld = 1'b0;

        // Asynchronous reset mid-slot discards all display data.
        wait_frame(c);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_an", {28'b0, ov_an}, 32'd0);
        check("arst_seg", {25'b0, ov_seg}, 32'd0);
        check("arst_dp", {31'b0, o_dp}, 32'd0);
        check("arst_frame", {31'b0, o_frame}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rec_frame", {31'b0, o_frame}, 32'd1);
        @(negedge clk);
        check("rec_an", {28'b0, ov_an}, 32'h1);
        check("rec_seg", {25'b0, ov_seg}, 32'h3F);

        // Single digit without guard: held enable, frame every ON period.
        @(posedge clk);
        #1;
        check("one_an_held", {31'b0, an2}, 32'd1);
        #2 rst2_n = 1'b0;
        #1;
        check("one_arst_an", {31'b0, an2}, 32'd0);
        check("one_arst_seg", {25'b0, seg2}, 32'd0);
        check("one_arst_frame", {31'b0, frame2}, 32'd0);
        repeat (2) @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        check("one_rec_frame", {31'b0, frame2}, 32'd1);
        @(negedge clk);
        check("one_rec_an", {31'b0, an2}, 32'd1);
        check("one_rec_seg", {25'b0, seg2}, 32'h3F);
        c = 1;
        while (frame2 !== 1'b1 && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("one_frame_period", c, 32'd4);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Time-multiplexed scan controller for a bank of common-anode/cathode 7-segment digits sharing one `Seg7` decoder. The block holds a frame of hex nibbles and steps through the digits at a programmable rate. For each digit it drives one digit enable and the decoded segments, with an all-off guard gap between digits to prevent ghosting. It sits between user logic (loads a display word) and the board pins, and is the only owner of the shared `Seg7` instance.

## Interface
- `DIGITS`, 4, number of digits scanned; must be ≥1.
- `ON_CYCLES`, 1000, clock cycles a digit enable stays asserted; must be ≥1.
- `GUARD_CYCLES`, 8, all-off cycles between digits; 0 disables the guard state.

Ports:
- `i_clk` in 1: system clock, rising edge.
- `i_rst_n` in 1: asynchronous active-low reset.
- `i_load` in 1: one-cycle strobe; captures `iv_data`, `iv_blank` and `iv_dp`.
- `iv_data` in 4*DIGITS: nibble k (bits 4k+3:4k) is shown on digit k.
- `iv_blank` in DIGITS: bit k=1 forces digit k segments to 0.
- `iv_dp` in DIGITS: decimal point per digit.
- `ov_an` out DIGITS: one-hot digit enable, active-high; all-zero during guard.
- `ov_seg` out 7: `Seg7` output for the current digit; 0 during guard or blank.
- `o_dp` out 1: decimal point for the current digit; 0 during guard.
- `o_frame` out 1: one-cycle pulse at each frame boundary.

## Operation
- Two register sets:
  - pending: data/blank/dp plus a valid flag.
  - active: data/blank/dp, the values currently displayed.
- `i_load`=1 at a clock edge writes the pending set and sets pending-valid. A later load before the boundary overwrites the pending set; the last load wins.
- Frame boundary = the cycle in which the digit index wraps from DIGITS-1 to 0 (entering digit 0's ON slot).
  - At the boundary, if pending-valid, active ← pending and pending-valid clears.
  - `o_frame` pulses in that same cycle.
- A load in the boundary cycle itself is written to pending only and is applied at the next boundary. If pending was already valid, the older pending set is promoted at this boundary.
- FSM states:
  - GUARD: counter counts GUARD_CYCLES; `ov_an`=0, `ov_seg`=0, `o_dp`=0. On expiry the index advances (mod DIGITS) and the FSM goes to ON.
  - ON: counter counts ON_CYCLES; `ov_an`=1<<index, `ov_seg`=blank[index] ? 0 : Seg7(data[index]), `o_dp`=dp[index]. On expiry the FSM goes to GUARD, or goes directly to the next ON when GUARD_CYCLES=0.
- Index width is $clog2(DIGITS), minimum 1. Counter width is $clog2 of max(ON_CYCLES, GUARD_CYCLES), minimum 1. The counter reloads to 0 on every state entry.
- DIGITS=1: the index stays 0. Every ON entry after a guard (or every ON restart when there is no guard) is a frame boundary.

## Timing
- Reset (async assert, takes effect immediately):
  - Outputs: `ov_an`=0, `ov_seg`=0, `o_dp`=0, `o_frame`=0.
  - Internal: active and pending data/blank/dp=0, pending-valid=0, index=DIGITS-1, state=GUARD, counter=0.
  - Consequence: the first ON slot after reset is digit 0 and is a frame boundary.
- Deassertion is treated as synchronous to `i_clk`. Reset mid-frame discards pending and active data.
- All outputs are registered. Segment decode is combinational from the active nibble into the output register.
  - Output changes appear the cycle after the state/index change.
  - A new frame is visible on pins one cycle after its `o_frame` pulse.
- Scan period per digit = ON_CYCLES + GUARD_CYCLES. Frame period = DIGITS × that.
- `ov_an` never has more than one bit set. It is all-zero for exactly GUARD_CYCLES between consecutive ON slots.

## Structure
- Shared package `seg7_pkg`: state enum (ST_GUARD, ST_ON) and the helper clog2-min-1 function.
- One sub-module, the existing `Seg7` (4-bit in, 7-bit out), instantiated once and fed by a mux over the active nibbles.
- Everything else (FSM, counter, index, shadow registers) lives in `seg7_scan`.

## Test plan
All scenarios use DIGITS=4, ON_CYCLES=4, GUARD_CYCLES=1 unless noted.
- Reset then idle:
  - `ov_an` sequence 0001,0010,0100,1000, each high 4 cycles with a 1-cycle 0000 gap.
  - `ov_seg`=Seg7(0).
  - `o_frame` pulses every 20 cycles.
- Load 16'h4321 mid-frame: the digits keep showing 0 until the next `o_frame`; afterwards digit0=Seg7(1) … digit3=Seg7(4), checked against a `Seg7Alt` reference.
- Two loads (16'hAAAA, then 16'hBEEF) before a boundary: only BEEF is ever displayed.
- Load asserted exactly in the `o_frame` cycle with 16'h1234, with no earlier pending: the old value is held one more frame, and 1234 appears after the following boundary.
- `iv_blank`=4'b0101, `iv_dp`=4'b1000: digits 0 and 2 show `ov_seg`=0, and `o_dp`=1 only while `ov_an`=1000.
- GUARD_CYCLES=0, DIGITS=1: `ov_an` is held at 1, with `o_frame` every 4 cycles. Asserting `i_rst_n`=0 mid-slot forces all outputs to 0 asynchronously, and recovery restarts at digit 0.
